// File: rtl/ext_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : ext_mem_model
// Purpose  : Behavioural external main memory serving cache refill and
//            writeback traffic, one request at a time, with a fixed read
//            latency, byte-masked line writes and tagged read responses.
// Revision : 1.0 - initial release
// ============================================================================
module ext_mem_model #(
    parameter int MEM_DATA_BITS = 128,
    parameter int MEM_TAG_BITS  = 5,
    parameter int MEM_ADDR_BITS = 28,
    parameter int DEPTH_BITS    = 16,
    parameter int READ_LATENCY  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_req_valid,
    output logic                       mem_req_ready,
    input  logic                       mem_req_rw,
    input  logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    input  logic [MEM_TAG_BITS-1:0]    mem_req_tag,
    input  logic                       mem_req_data_valid,
    output logic                       mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                       mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   mem_resp_data,
    output logic [MEM_TAG_BITS-1:0]    mem_resp_tag
);

    localparam int C_MASK_W = MEM_DATA_BITS / 8;
    localparam int C_CNT_W  = $clog2(READ_LATENCY + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WDATA = 2'd1;
    localparam logic [1:0] S_RWAIT = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Line storage; preloaded hierarchically and deliberately not reset.
    logic [MEM_DATA_BITS-1:0] ram [0:(1 << DEPTH_BITS) - 1];

    logic [1:0]               state_q, state_d;
    logic [C_CNT_W-1:0]       cnt_q, cnt_d;
    logic [DEPTH_BITS-1:0]    idx_q, idx_d;
    logic [MEM_TAG_BITS-1:0]  tag_q, tag_d;
    logic                     live_q;
    logic [MEM_DATA_BITS-1:0] resp_data_q;
    logic [MEM_TAG_BITS-1:0]  resp_tag_q;

    // Upper address bits only alias; they are intentionally not decoded.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_req_addr[MEM_ADDR_BITS-1:DEPTH_BITS];

    // Next-state logic for the request sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tag_d   = tag_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req_valid && live_q) begin
                    idx_d = mem_req_addr[DEPTH_BITS-1:0];
                    if (mem_req_rw) begin
                        state_d = S_WDATA;
                    end else begin
                        tag_d = mem_req_tag;
                        if (READ_LATENCY == 1) begin
                            state_d = S_RESP;
                        end else begin
                            state_d = S_RWAIT;
                            cnt_d   = C_CNT_W'(READ_LATENCY - 1);
                        end
                    end
                end
            end
            S_RWAIT: begin
                if (cnt_q == C_CNT_W'(1)) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - C_CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            S_WDATA: begin
                if (mem_req_data_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latched request fields and response registers.
    // live_q keeps the request channel closed until the first edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            tag_q       <= '0;
            live_q      <= 1'b0;
            resp_data_q <= '0;
            resp_tag_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            live_q  <= 1'b1;
            if (state_d == S_RESP) begin
                resp_data_q <= ram[idx_d];
                resp_tag_q  <= tag_d;
            end
        end
    end

    // Byte-masked line write at the edge that takes the write data.
    always @(posedge clk) begin
        if (reset && (state_q == S_WDATA) && mem_req_data_valid) begin
            for (int i = 0; i < C_MASK_W; i++) begin
                if (mem_req_data_mask[i]) begin
                    ram[idx_q][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
                end
            end
        end
    end

    assign mem_req_ready      = live_q && (state_q == S_IDLE);
    assign mem_req_data_ready = (state_q == S_WDATA);
    assign mem_resp_valid     = (state_q == S_RESP);
    assign mem_resp_data      = resp_data_q;
    assign mem_resp_tag       = resp_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_mem_model
// Purpose  : Self-checking bench for ext_mem_model: transaction-level memory
//            model, per-cycle output compare and literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_mem_model;

    localparam int L   = 2;
    localparam int INF = 32'h7fff_ffff;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [4:0]   mem_req_tag;
    logic         mem_req_data_valid;
    logic         mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic [4:0]   mem_resp_tag;

    ext_mem_model #(
        .MEM_DATA_BITS(128), .MEM_TAG_BITS(5), .MEM_ADDR_BITS(28),
        .DEPTH_BITS(16), .READ_LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_tag(mem_req_tag),
        .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits),
        .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .mem_resp_tag(mem_resp_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state.
    logic [127:0] mdl [int];
    int           ready_from = INF;
    bit           wr_pending = 1'b0;
    int           wr_idx     = 0;
    int           resp_cyc   = -1;
    logic [127:0] exp_data   = '0;
    logic [4:0]   exp_tag    = '0;
    logic [127:0] hold_data  = '0;
    logic [4:0]   hold_tag   = '0;
    bit           chk_en     = 1'b0;

    // Last observed response, for literal spot checks.
    logic [127:0] seen_data = '0;
    logic [4:0]   seen_tag  = '0;
    int           seen_cyc  = -1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", {127'b0, mem_req_ready}, {127'b0, (!wr_pending && cyc >= ready_from)});
            chk("data_ready", {127'b0, mem_req_data_ready}, {127'b0, wr_pending});
            chk("resp_valid", {127'b0, mem_resp_valid}, {127'b0, (cyc == resp_cyc)});
            if (cyc == resp_cyc) begin
                hold_data = exp_data;
                hold_tag  = exp_tag;
            end
            chk("resp_data", mem_resp_data, hold_data);
            chk("resp_tag", {123'b0, mem_resp_tag}, {123'b0, hold_tag});
            if (mem_resp_valid) begin
                seen_data = mem_resp_data;
                seen_tag  = mem_resp_tag;
                seen_cyc  = cyc;
            end
        end
    end

    task automatic req(input bit w, input logic [27:0] a, input logic [4:0] t, output int n);
        bit acc;
        bit done;
        int idx;
        done = 1'b0;
        @(negedge clk);
        mem_req_valid = 1'b1; mem_req_rw = w; mem_req_addr = a; mem_req_tag = t;
        for (int k = 0; k < 40; k++) begin
            acc = mem_req_ready;
            @(posedge clk);
            if (acc) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        n = cyc;
        mem_req_valid = 1'b0; mem_req_rw = ~w; mem_req_addr = 28'hFFF_FFFF; mem_req_tag = 5'h1F;
        if (!done) begin
            chk("req_accept_timeout", 128'd0, 128'd1);
        end else begin
            idx = int'(a[15:0]);
            if (!w) begin
                resp_cyc   = n + L - 1;
                exp_data   = mdl.exists(idx) ? mdl[idx] : 128'd0;
                exp_tag    = t;
                ready_from = n + L;
            end else begin
                wr_pending = 1'b1;
                wr_idx     = idx;
                ready_from = INF;
            end
        end
    endtask

    task automatic wdata(input logic [127:0] d, input logic [15:0] m, input int stall, output int dc);
        bit acc;
        bit done;
        logic [127:0] line;
        done = 1'b0;
        repeat (stall) @(negedge clk);
        @(negedge clk);
        mem_req_data_valid = 1'b1; mem_req_data_bits = d; mem_req_data_mask = m;
        for (int k = 0; k < 40; k++) begin
            acc = mem_req_data_ready;
            @(posedge clk);
            if (acc) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        dc = cyc;
        mem_req_data_valid = 1'b0; mem_req_data_bits = ~d; mem_req_data_mask = 16'hFFFF;
        if (!done) begin
            chk("wdata_accept_timeout", 128'd0, 128'd1);
        end else begin
            line = mdl[wr_idx];
            for (int i = 0; i < 16; i++) begin
                if (m[i]) line[8*i +: 8] = d[8*i +: 8];
            end
            mdl[wr_idx] = line;
            wr_pending  = 1'b0;
            ready_from  = dc;
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!wr_pending && cyc >= ready_from) break;
        end
    endtask

    task automatic assert_reset();
        reset      = 1'b0;
        resp_cyc   = -1;
        wr_pending = 1'b0;
        ready_from = INF;
        hold_data  = '0;
        hold_tag   = '0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        reset      = 1'b1;
        ready_from = cyc + 1;
    endtask

    logic [127:0] c_line10 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    logic [127:0] c_line05 = 128'hDEADBEEF_0BADF00D_CAFEBABE_13579BDF;
    logic [127:0] c_line40 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    logic [127:0] c_line20 = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    logic [127:0] c_a5     = {16{8'hA5}};
    logic [127:0] c_ones   = {128{1'b1}};

    initial begin
        int n, na, nb, d;
        reset = 1'b1;
        mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_addr = '0; mem_req_tag = '0;
        mem_req_data_valid = 1'b0; mem_req_data_bits = '0; mem_req_data_mask = '0;

        dut.ram[16'h0010] = c_line10; mdl[16'h0010] = c_line10;
        dut.ram[16'h0020] = c_line20; mdl[16'h0020] = c_line20;
        dut.ram[16'h0030] = 128'd0;   mdl[16'h0030] = 128'd0;
        dut.ram[16'h0005] = c_line05; mdl[16'h0005] = c_line05;
        dut.ram[16'h0040] = c_line40; mdl[16'h0040] = c_line40;

        #1 assert_reset();
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready_lit", {127'b0, mem_req_ready}, 128'd0);
        release_reset();

        // Preload and read.
        req(1'b0, 28'h10, 5'd3, n);
        wait_idle();
        chk("read10_data_lit", seen_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        chk("read10_tag_lit", {123'b0, seen_tag}, 128'd3);
        chk("read10_latency_lit", 128'(seen_cyc - n), 128'd1);

        // Full-mask write then read back.
        req(1'b1, 28'h20, 5'd0, n);
        wdata(c_a5, 16'hFFFF, 0, d);
        wait_idle();
        req(1'b0, 28'h20, 5'd7, n);
        wait_idle();
        chk("read20_data_lit", seen_data, {16{8'hA5}});

        // Partial-mask write with a five-cycle data stall.
        req(1'b1, 28'h30, 5'd0, n);
        wdata(c_ones, 16'h0003, 5, d);
        chk("stall_len_lit", {127'b0, (d - n) >= 6}, 128'd1);
        wait_idle();
        req(1'b0, 28'h30, 5'd9, n);
        wait_idle();
        chk("read30_data_lit", seen_data, 128'h0000FFFF);
        chk("read30_tag_lit", {123'b0, seen_tag}, 128'd9);

        // Back-to-back reads: second request held until the model is idle.
        req(1'b0, 28'h40, 5'd1, na);
        req(1'b0, 28'h10, 5'd2, nb);
        chk("b2b_spacing_lit", 128'(nb - na), 128'd3);
        wait_idle();

        // Write data presented while idle must be ignored.
        @(negedge clk);
        mem_req_data_valid = 1'b1; mem_req_data_bits = c_ones; mem_req_data_mask = 16'hFFFF;
        repeat (2) @(negedge clk);
        mem_req_data_valid = 1'b0;
        req(1'b0, 28'h10, 5'd11, n);
        wait_idle();

        // Aliasing of upper address bits.
        req(1'b0, 28'h001_0005, 5'd4, n);
        wait_idle();
        chk("alias_data_lit", seen_data, 128'hDEADBEEF_0BADF00D_CAFEBABE_13579BDF);

        // Reset during the read wait: no response, then a clean re-read.
        req(1'b0, 28'h10, 5'd6, n);
        #1 assert_reset();
        repeat (3) @(negedge clk);
        chk("midrst_valid_lit", {127'b0, mem_resp_valid}, 128'd0);
        chk("midrst_data_lit", mem_resp_data, 128'd0);
        release_reset();
        req(1'b0, 28'h10, 5'd6, n);
        wait_idle();
        chk("postrst_data_lit", seen_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);

        // Reset while write data is pending drops the write.
        req(1'b1, 28'h10, 5'd0, n);
        #1 assert_reset();
        repeat (2) @(negedge clk);
        release_reset();
        req(1'b0, 28'h10, 5'd12, n);
        wait_idle();
        chk("dropped_wr_lit", seen_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
